// File: rtl/mpd_io_cfg_loader.sv
// ---------------------------------------------------------------------------
// mpd_io_cfg_loader
//
// Loads per-IO configuration words from a byte stream and publishes them to
// the IO controllers atomically. Each IO takes one 12-bit word sent as two
// bytes: the low byte first (bits [7:0]), then a byte whose low nibble is
// bits [11:8] and whose high nibble must be zero. Bytes are collected in a
// shadow copy. The whole shadow is copied to fabric_config in a single
// COMMIT cycle, so fabric_done never qualifies a partial or stale load.
//
// Parameters
//   NUM_IO         number of user IOs configured (one 12-bit word each)
//
// Ports
//   wb_clk_i       clock; all state updates on its rising edge
//   wb_rst_i       synchronous active-high reset
//   cfg_start      one-cycle pulse that begins a new load (from any state)
//   cfg_valid      byte-stream valid
//   cfg_data       byte-stream data
//   cfg_ready      byte-stream ready (only in LOAD and not while cfg_start)
//   fabric_done    committed configuration is valid
//   fabric_config  committed configuration; [12*i+11:12*i] belongs to IO i
//   cfg_error      malformed stream detected; held until cfg_start or reset
//   cfg_busy       load in progress (LOAD or COMMIT)
// ---------------------------------------------------------------------------
module mpd_io_cfg_loader #(
    parameter int NUM_IO = 38
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    input  logic [7:0]             cfg_data,
    output logic                   cfg_ready,
    output logic                   fabric_done,
    output logic [NUM_IO*12-1:0]   fabric_config,
    output logic                   cfg_error,
    output logic                   cfg_busy
);

    localparam int NB = 2 * NUM_IO;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                 state;
    logic [KW-1:0]          k;        // index of the next byte in the stream
    logic [NUM_IO*12-1:0]   shadow;   // load in progress, not yet visible
    logic                   accept;
    logic                   odd_bad;

    // A start pulse takes precedence, so no byte is taken in that cycle.
    assign cfg_ready = (state == ST_LOAD) & ~cfg_start;
    assign cfg_busy  = (state == ST_LOAD) | (state == ST_COMMIT);
    assign accept    = cfg_valid & cfg_ready;

    // The second byte of a word carries only four payload bits; anything in
    // the upper nibble means the stream is out of step.
    assign odd_bad   = k[0] & (cfg_data[7:4] != 4'h0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            // NOTE: the shadow store is reset too, so a load aborted by reset
            // can never leak old bytes into a later commit.
            state         <= ST_IDLE;
            k             <= '0;
            shadow        <= '0;
            fabric_config <= '0;
            fabric_done   <= 1'b0;
            cfg_error     <= 1'b0;
        end else if (cfg_start) begin
            state       <= ST_LOAD;
            k           <= '0;
            fabric_done <= 1'b0;
            cfg_error   <= 1'b0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (odd_bad) begin
                            state     <= ST_ERROR;
                            cfg_error <= 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_IO; i++) begin
                                if (int'(k >> 1) == i) begin
                                    if (k[0])
                                        shadow[12*i+8 +: 4] <= cfg_data[3:0];
                                    else
                                        shadow[12*i +: 8]   <= cfg_data;
                                end
                            end
                            k <= k + 1'b1;
                            if (k == K_LAST)
                                state <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    // Config and its qualifier change on the same edge.
                    fabric_config <= shadow;
                    fabric_done   <= 1'b1;
                    state         <= ST_DONE;
                end
                default: begin
                    // IDLE, DONE and ERROR hold until cfg_start or reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpd_io_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_mpd_io_cfg_loader
//
// Bench for mpd_io_cfg_loader with NUM_IO=2. The stimulus side issues loads
// and pushes the expected outcome of each (committed config, or error with
// the old config kept) into a queue. A monitor pops one entry whenever the
// DUT raises fabric_done or cfg_error and compares it. Directed sequences
// cover reset, ignored bytes, gaps, the error path, restart and reset
// mid-load; a randomized loop follows.
// ---------------------------------------------------------------------------
module tb_mpd_io_cfg_loader;

    localparam int NUM_IO = 2;
    localparam int NB     = 2 * NUM_IO;
    localparam int CW     = NUM_IO * 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_start = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [7:0]        cfg_data  = 8'h00;
    logic              cfg_ready;
    logic              fabric_done;
    logic [CW-1:0]     fabric_config;
    logic              cfg_error;
    logic              cfg_busy;

    mpd_io_cfg_loader #(.NUM_IO(NUM_IO)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .cfg_start     (cfg_start),
        .cfg_valid     (cfg_valid),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .fabric_done   (fabric_done),
        .fabric_config (fabric_config),
        .cfg_error     (cfg_error),
        .cfg_busy      (cfg_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] cfg;
        logic          done;
        logic          err;
    } exp_t;

    exp_t          sb_q[$];
    logic [CW-1:0] model_cfg = '0;   // last committed configuration
    int            vectors    = 0;
    int            miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;

    always @(negedge clk) begin
        if (!rst && ((fabric_done === 1'b1 && prev_done !== 1'b1) ||
                     (cfg_error === 1'b1 && prev_err !== 1'b1))) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected: done=%b err=%b with nothing expected (t=%0t)",
                         fabric_done, cfg_error, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_config", 32'(fabric_config), 32'(e.cfg));
                check("sb_done",   32'(fabric_done),   32'(e.done));
                check("sb_error",  32'(cfg_error),     32'(e.err));
            end
        end
        prev_done <= fabric_done;
        prev_err  <= cfg_error;
    end

    // ---------------- reference model ----------------
    // Outcome of a complete byte sequence: the index of the first odd byte
    // with a nonzero high nibble (or -1), and the config it would commit.
    function automatic int first_bad(input logic [7:0] b[NB]);
        for (int j = 1; j < NB; j += 2)
            if (b[j][7:4] != 4'h0) return j;
        return -1;
    endfunction

    function automatic logic [CW-1:0] assemble(input logic [7:0] b[NB]);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_IO; i++)
            c[12*i +: 12] = {b[2*i+1][3:0], b[2*i]};
        return c;
    endfunction

    // ---------------- drivers ----------------
    task automatic start_pulse(input logic with_byte, input logic [7:0] d);
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_valid = with_byte;
        cfg_data  = d;
        #1;
        check("start_ready_low", 32'(cfg_ready), 32'd0);
        @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int w;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        #1;
        w = 0;
        while (cfg_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (cfg_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: cfg_ready=%b after %0d cycles, expected 1", cfg_ready, w);
        end
        @(posedge clk);
    endtask

    task automatic gap(input int n);
        if (n > 0) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            repeat (n - 1) @(negedge clk);
        end
    endtask

    // Presents a byte for one cycle without waiting for ready; it must be ignored.
    task automatic junk_byte(input logic [7:0] d);
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        #1;
        check("junk_ready_low", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Full load: start, the bytes (stopping after a malformed one), then the
    // commit or error outcome checked at its exact cycle.
    task automatic issue_load(input logic [7:0] b[NB], input int gap_cycles);
        int   bad;
        exp_t e;
        bad = first_bad(b);
        if (bad < 0) begin
            model_cfg = assemble(b);
            e.cfg = model_cfg; e.done = 1'b1; e.err = 1'b0;
        end else begin
            e.cfg = model_cfg; e.done = 1'b0; e.err = 1'b1;
        end
        sb_q.push_back(e);
        start_pulse(1'b0, 8'h00);
        for (int j = 0; j < NB; j++) begin
            send_byte(b[j]);
            if (j == bad) break;
            if (j != NB - 1) gap(gap_cycles);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        if (bad < 0) begin
            check("commit_busy",  32'(cfg_busy),    32'd1);
            check("commit_done0", 32'(fabric_done), 32'd0);
            @(negedge clk);
            check("done_set",    32'(fabric_done), 32'd1);
            check("done_busy0",  32'(cfg_busy),    32'd0);
            check("done_config", 32'(fabric_config), 32'(model_cfg));
        end else begin
            check("err_set",    32'(cfg_error),   32'd1);
            check("err_done0",  32'(fabric_done), 32'd0);
            check("err_ready0", 32'(cfg_ready),   32'd0);
            check("err_busy0",  32'(cfg_busy),    32'd0);
            check("err_config", 32'(fabric_config), 32'(model_cfg));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_config"}, 32'(fabric_config), 32'd0);
        check({tag, "_done"},   32'(fabric_done),   32'd0);
        check({tag, "_ready"},  32'(cfg_ready),     32'd0);
        check({tag, "_busy"},   32'(cfg_busy),      32'd0);
        check({tag, "_error"},  32'(cfg_error),     32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] nominal[NB];
        logic [7:0] bad_seq[NB];
        logic [7:0] rb[NB];
        nominal = '{8'hAB, 8'h0C, 8'h34, 8'h05};
        bad_seq = '{8'h11, 8'h1C, 8'h00, 8'h00};

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("reset");

        // Byte in IDLE is ignored, then nominal load back-to-back
        junk_byte(8'hFF);
        check_all_zero("idle_byte");
        issue_load(nominal, 0);
        check("nominal_value", 32'(fabric_config), 32'h534CAB);

        // Same bytes with three idle cycles between each; a byte in DONE is ignored
        junk_byte(8'hFF);
        check("done_hold", 32'(fabric_done), 32'd1);
        issue_load(nominal, 3);
        check("gapped_value", 32'(fabric_config), 32'h534CAB);

        // Error path keeps the committed config
        issue_load(bad_seq, 0);
        repeat (3) @(negedge clk);
        check("err_hold",        32'(cfg_error),     32'd1);
        check("err_hold_config", 32'(fabric_config), 32'h534CAB);

        // Restart mid-load; the byte beside the second start is not taken
        begin
            exp_t e;
            e.cfg = 24'h988766; e.done = 1'b1; e.err = 1'b0;
            sb_q.push_back(e);
            model_cfg = 24'h988766;
            start_pulse(1'b0, 8'h00);
            send_byte(8'h22);
            send_byte(8'h03);
            start_pulse(1'b1, 8'h55);
            send_byte(8'h66);
            send_byte(8'h07);
            send_byte(8'h88);
            send_byte(8'h09);
            @(negedge clk);
            cfg_valid = 1'b0;
            @(negedge clk);
            check("restart_done",   32'(fabric_done),   32'd1);
            check("restart_config", 32'(fabric_config), 32'h988766);
        end

        // Reset after three of four bytes; the fourth is then ignored
        start_pulse(1'b0, 8'h00);
        send_byte(8'h12);
        send_byte(8'h03);
        send_byte(8'h45);
        @(negedge clk);
        cfg_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_cfg = '0;
        #1;
        check_all_zero("rst_mid");
        junk_byte(8'h06);
        repeat (2) @(negedge clk);
        check_all_zero("rst_after");

        // Randomized loads with random gaps and occasional malformed bytes
        for (int n = 0; n < 30; n++) begin
            for (int j = 0; j < NB; j++) begin
                rb[j] = 8'($urandom);
                if (j % 2 == 1 && $urandom_range(0, 9) < 8)
                    rb[j][7:4] = 4'h0;
            end
            issue_load(rb, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) junk_byte(8'($urandom));
        end

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Backstop so the run always ends even if a driver stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $finish;
    end

endmodule

// File: doc/mpd_io_cfg_loader.md
MPD_IO_CFG_LOADER -- requirements
Module: mpd_io_cfg_loader

Interface
REQ-001 SHALL have parameter NUM_IO, default 38, meaning the number of user IOs configured; each IO takes one 12-bit config word.
REQ-002 SHALL have port wb_clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst_i  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port cfg_start  in  1  one-cycle pulse that begins a new load.
REQ-005 SHALL have port cfg_valid  in  1  byte-stream valid.
REQ-006 SHALL have port cfg_data  in  8  byte-stream data.
REQ-007 SHALL have port cfg_ready  out  1  byte-stream ready.
REQ-008 SHALL have port fabric_done  out  1  committed config valid; drives each IO controller's fabric_done.
REQ-009 SHALL have port fabric_config  out  NUM_IO*12  committed config; bits [12*i+11:12*i] drive IO i's fabric_config.
REQ-010 SHALL have port cfg_error  out  1  malformed stream detected.
REQ-011 SHALL have port cfg_busy  out  1  load in progress.

Function
REQ-012 SHALL implement states IDLE, LOAD, COMMIT, DONE and ERROR.
REQ-013 SHALL accept a byte only when cfg_valid and cfg_ready are both 1 at a clock edge.
REQ-014 SHALL drive cfg_ready = (state==LOAD) & ~cfg_start, combinationally.
REQ-015 SHALL keep a byte index k, width clog2(2*NUM_IO), cleared on entry to LOAD and incremented per accepted byte.
REQ-016 SHALL write an accepted byte to a shadow register for IO i = k>>1.
  - Even k: data[7:0] goes to shadow bits [7:0].
  - Odd k: data[3:0] goes to shadow bits [11:8].
REQ-017 SHALL, on an odd-k byte with data[7:4] != 0, leave the shadow unwritten for that byte and go to ERROR.
REQ-018 SHALL go to COMMIT when byte k = 2*NUM_IO-1 is accepted without error.
REQ-019 SHALL, in COMMIT (exactly one cycle), copy all shadow registers into fabric_config and set fabric_done=1 on the same edge, then enter DONE.
  - fabric_done SHALL never be 1 while fabric_config holds a partial or stale load.
REQ-020 SHALL leave fabric_config unchanged outside the COMMIT edge; it holds its last committed value through LOAD and ERROR.
REQ-021 SHALL, on cfg_start in any state, go to LOAD on the next edge with fabric_done=0, cfg_error=0, k=0.
  - A byte presented in the same cycle as cfg_start is not accepted.
REQ-022 SHALL ignore cfg_valid in IDLE, COMMIT, DONE and ERROR.
REQ-023 SHALL support arbitrary gaps (cfg_valid=0) between bytes without a timeout; LOAD persists.
REQ-024 SHALL drive cfg_busy=1 exactly in LOAD and COMMIT.
REQ-025 SHALL register cfg_error=1 on the ERROR entry edge and hold it until cfg_start or reset.
  - fabric_done stays 0 while cfg_error=1.
REQ-026 SHALL stay in DONE, holding fabric_done=1, until cfg_start or reset.

Reset
REQ-027 SHALL, with wb_rst_i=1 at an edge, set the state to IDLE.
  - Cleared to 0: k, all shadow registers, fabric_config, fabric_done, cfg_error.
  - Resulting outputs: cfg_ready=0, cfg_busy=0.
REQ-028 SHALL give wb_rst_i priority over cfg_start and any handshake in the same cycle, including reset mid-LOAD or during COMMIT.

Verification (NUM_IO=2)
REQ-029 SHALL cover reset: after a wb_rst_i pulse -> fabric_config=24'h0; fabric_done, cfg_ready, cfg_busy and cfg_error all 0.
REQ-030 SHALL cover a nominal load: cfg_start, then bytes 0xAB, 0x0C, 0x34, 0x05 back-to-back.
  - Required: fabric_config=24'h534CAB and fabric_done=1 on the edge after the COMMIT cycle.
  - Required: cfg_busy=0 afterwards.
REQ-031 SHALL cover backpressure gaps and ignored bytes.
  - Same four bytes with 3 idle cycles between each, plus cfg_valid=1 with data 0xFF while in IDLE.
  - Required: identical result, and the IDLE byte is ignored.
REQ-032 SHALL cover the error path: after the REQ-030 load, cfg_start then bytes 0x11, 0x1C.
  - Required: cfg_error=1, fabric_done=0, fabric_config stays 24'h534CAB, cfg_ready=0.
REQ-033 SHALL cover restart mid-load: cfg_start, bytes 0x22, 0x03, then cfg_start with cfg_valid=1 in the same cycle, then bytes 0x66, 0x07, 0x88, 0x09.
  - Required: the same-cycle byte is not accepted.
  - Required: fabric_config=24'h988766, fabric_done=1.
REQ-034 SHALL cover reset mid-load: wb_rst_i after 3 of 4 bytes.
  - Required: all outputs 0 and state IDLE.
  - Required: a subsequent 4th byte with cfg_valid=1 is ignored.
